// File: rtl/kram_loader.sv
// Kernel RAM loader: streams weight words into the idle ping-pong slot of the KRAM bank array.
// Optional build macro KRAM_LOADER_ZERO_PAD_EN zero-fills the slot after an early s_last. PE_NUM must be a power of two >= 2.
module kram_loader #(
    parameter int PE_NUM  = 16,
    parameter int DATA_W  = 8,
    parameter int BANK_AW = 9
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [BANK_AW-1:0]            cfg_rows,
    input  logic                          s_valid,
    input  logic [DATA_W-1:0]             s_data,
    input  logic                          s_last,
    output logic                          s_ready,
    input  logic                          slot_release,
    input  logic                          rel_slot,
    output logic [1:0]                    slot_full,
    output logic                          wr_slot,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    output logic [2*PE_NUM*BANK_AW-1:0]   bram_addr_a,
    output logic [2*PE_NUM*DATA_W-1:0]    bram_wdata_a,
    output logic [2*PE_NUM-1:0]           bram_we_a,
    output logic [2*PE_NUM-1:0]           bram_en_a
);

    localparam int NB     = 2 * PE_NUM;
    localparam int LANE_W = $clog2(PE_NUM);
    localparam int K_W    = LANE_W + BANK_AW;
    localparam int BSEL_W = LANE_W + 1;

    typedef enum logic [2:0] {ST_IDLE, ST_WAIT, ST_LOAD, ST_PAD, ST_DONE} state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [BANK_AW-1:0]      r_rows;
    logic [K_W-1:0]          r_k;
    logic                    r_wr_slot;
    logic [1:0]              r_slot_full;
    logic                    r_err;
    logic [NB*BANK_AW-1:0]   r_addr_a;
    logic [NB*DATA_W-1:0]    r_wdata_a;
    logic [NB-1:0]           r_we_a;
    logic [NB-1:0]           r_en_a;

    logic                    w_ready;
    logic                    w_hs;
    logic                    w_wr;
    logic [DATA_W-1:0]       w_wdata;
    logic [LANE_W-1:0]       w_k_lane;
    logic [BANK_AW-1:0]      w_k_row;
    logic                    w_last_word;
    logic [BSEL_W-1:0]       w_bank;
    logic                    w_rel_hit;

    // Word k maps to lane k % PE_NUM and row k / PE_NUM; with PE_NUM a power of two these are bit fields of k.
    assign w_k_lane    = r_k[LANE_W-1:0];
    assign w_k_row     = r_k[K_W-1:LANE_W];
    assign w_last_word = (w_k_row == r_rows) && (&w_k_lane);
    assign w_bank      = {r_wr_slot, w_k_lane};
    assign w_hs        = s_valid && (r_state == ST_LOAD);
    assign w_rel_hit   = slot_release && (rel_slot == r_wr_slot);

`ifdef KRAM_LOADER_ZERO_PAD_EN
    assign w_wr    = w_hs || (r_state == ST_PAD);
    assign w_wdata = (r_state == ST_PAD) ? '0 : s_data;
`else
    assign w_wr    = w_hs;
    assign w_wdata = s_data;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        case (r_state)
            ST_IDLE: if (start) w_next = r_slot_full[r_wr_slot] ? ST_WAIT : ST_LOAD;
            // A release of the target slot lets the load start on the following cycle.
            ST_WAIT: if (!r_slot_full[r_wr_slot] || w_rel_hit) w_next = ST_LOAD;
            ST_LOAD: begin
                w_ready = 1'b1;
                if (w_hs && w_last_word) w_next = ST_DONE;
`ifdef KRAM_LOADER_ZERO_PAD_EN
                else if (w_hs && s_last) w_next = ST_PAD;
`endif
            end
`ifdef KRAM_LOADER_ZERO_PAD_EN
            ST_PAD:  if (w_last_word) w_next = ST_DONE;
`endif
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rows      <= '0;
            r_k         <= '0;
            r_wr_slot   <= 1'b0;
            r_slot_full <= 2'b00;
            r_err       <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && start) begin
                r_rows <= cfg_rows;
                r_k    <= '0;
                r_err  <= 1'b0;
            end
            if (w_wr) r_k <= r_k + 1'b1;
            if (w_hs) begin
`ifdef KRAM_LOADER_ZERO_PAD_EN
                if (w_last_word && !s_last) r_err <= 1'b1;
`else
                if (s_last != w_last_word) r_err <= 1'b1;
`endif
            end
            // Set after clear so a completing fill beats a same-cycle release of that slot.
            if (slot_release) r_slot_full[rel_slot] <= 1'b0;
            if (r_state == ST_DONE) begin
                r_slot_full[r_wr_slot] <= 1'b1;
                r_wr_slot              <= ~r_wr_slot;
            end
        end
    end

    // PORTA register stage: exactly one bank is driven the cycle after each write, all others idle at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr_a  <= '0;
            r_wdata_a <= '0;
            r_we_a    <= '0;
            r_en_a    <= '0;
        end else begin
            r_addr_a  <= '0;
            r_wdata_a <= '0;
            r_we_a    <= '0;
            r_en_a    <= '0;
            if (w_wr) begin
                r_we_a[w_bank]                             <= 1'b1;
                r_en_a[w_bank]                             <= 1'b1;
                r_addr_a[int'(w_bank)*BANK_AW +: BANK_AW]  <= w_k_row;
                r_wdata_a[int'(w_bank)*DATA_W +: DATA_W]   <= w_wdata;
            end
        end
    end

    assign s_ready      = w_ready;
    assign slot_full    = r_slot_full;
    assign wr_slot      = r_wr_slot;
    assign busy         = (r_state != ST_IDLE);
    assign done         = (r_state == ST_DONE);
    assign err          = r_err;
    assign bram_addr_a  = r_addr_a;
    assign bram_wdata_a = r_wdata_a;
    assign bram_we_a    = r_we_a;
    assign bram_en_a    = r_en_a;

endmodule
